// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - ASCON p^a/p^b permutation engine, start/busy/done handshake, UNROLL rounds per clock
module ascon_perm_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [319:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [319:0] state_out
);

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("ascon_perm_engine: UNROLL must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    fsm_t         r_fsm;
    fsm_t         w_fsm_nxt;
    logic [319:0] r_state;
    logic [319:0] w_state_nxt;
    logic [3:0]   r_ridx;
    logic [3:0]   w_ridx_nxt;
    logic [3:0]   r_rem;
    logic [3:0]   w_rem_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic [3:0]   w_nr;
    logic [3:0]   w_step;
    logic [319:0] w_round1;
    logic [319:0] w_round2;
    logic [319:0] w_run_state;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'b0, 4'hF - i, i};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Out-of-range round counts fall back to the full 12-round p^a
    assign w_nr = (rounds == 4'd0 || rounds > 4'd12) ? 4'd12 : rounds;

    // Second round index may reach 12 when only one round remains; its result is then unused
    assign w_round1    = ascon_round(r_state, r_ridx);
    assign w_round2    = ascon_round(w_round1, r_ridx + 4'd1);
    assign w_step      = (UNROLL == 2 && r_rem >= 4'd2) ? 4'd2 : 4'd1;
    assign w_run_state = (w_step == 4'd2) ? w_round2 : w_round1;

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_ridx_nxt  = r_ridx;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = state_in;
                    w_ridx_nxt  = 4'd12 - w_nr;
                    w_rem_nxt   = w_nr;
                    w_fsm_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = w_run_state;
                w_ridx_nxt  = r_ridx + w_step;
                w_rem_nxt   = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_fsm_nxt  = S_IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_ridx  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_ridx  <= w_ridx_nxt;
            r_rem   <= w_rem_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy      = (r_fsm == S_RUN);
    assign done      = r_done;
    assign state_out = r_state;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - scoreboard bench for ascon_perm_engine, UNROLL=1 and UNROLL=2 side by side
module tb_ascon_perm_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic         busy1, done1, busy2, done2;
    logic [319:0] so1, so2;

    ascon_perm_engine #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds), .state_in(state_in),
        .busy(busy1), .done(done1), .state_out(so1)
    );

    ascon_perm_engine #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds), .state_in(state_in),
        .busy(busy2), .done(done2), .state_out(so2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [319:0] st;
        int           dc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc  = 0;
    int   m1   = 0;
    int   m2   = 0;
    int   vec  = 0;
    int   errs = 0;

    function automatic int clamp_nr(input logic [3:0] r);
        return (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
    endfunction

    function automatic int nsteps(input logic [3:0] r, input int u);
        return (clamp_nr(r) + u - 1) / u;
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [63:0] x[5];
        logic [63:0] t[5];
        for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int j = 0; j < 5; j++) t[j] = ~x[j] & x[(j + 1) % 5];
            for (int j = 0; j < 5; j++) x[j] ^= t[(j + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            x[0] ^= rot(x[0], 19) ^ rot(x[0], 28);
            x[1] ^= rot(x[1], 61) ^ rot(x[1], 39);
            x[2] ^= rot(x[2], 1)  ^ rot(x[2], 6);
            x[3] ^= rot(x[3], 10) ^ rot(x[3], 17);
            x[4] ^= rot(x[4], 7)  ^ rot(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        vec++;
        errs++;
        $display("FAIL %s", nm);
    endtask

    // Reference protocol: accepts start only when idle, predicts the done cycle and result
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q2.delete();
            m1 <= 0;
            m2 <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m1 == 0 && start) begin
                q1.push_back('{st: ref_perm(state_in, clamp_nr(rounds)), dc: cyc + 1 + nsteps(rounds, 1)});
                m1 <= nsteps(rounds, 1);
            end else if (m1 > 0) begin
                m1 <= m1 - 1;
            end
            if (m2 == 0 && start) begin
                q2.push_back('{st: ref_perm(state_in, clamp_nr(rounds)), dc: cyc + 1 + nsteps(rounds, 2)});
                m2 <= nsteps(rounds, 2);
            end else if (m2 > 0) begin
                m2 <= m2 - 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done1) begin
                if (q1.size() == 0) fail_now("u1 spurious done");
                else begin
                    e = q1.pop_front();
                    chk("u1 done cycle", 320'(cyc), 320'(e.dc));
                    chk("u1 result", so1, e.st);
                end
            end else if (q1.size() > 0 && q1[0].dc <= cyc) begin
                fail_now("u1 missing done");
                void'(q1.pop_front());
            end
            if (done2) begin
                if (q2.size() == 0) fail_now("u2 spurious done");
                else begin
                    e = q2.pop_front();
                    chk("u2 done cycle", 320'(cyc), 320'(e.dc));
                    chk("u2 result", so2, e.st);
                end
            end else if (q2.size() > 0 && q2[0].dc <= cyc) begin
                fail_now("u2 missing done");
                void'(q2.pop_front());
            end
        end
    end

    task automatic issue(input logic [3:0] r, input logic [319:0] st);
        @(negedge clk);
        rounds   = r;
        state_in = st;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && (q1.size() != 0 || q2.size() != 0); k++) @(negedge clk);
        if (q1.size() != 0 || q2.size() != 0) fail_now("timeout waiting for done");
        repeat (2) @(negedge clk);
    endtask

    logic [319:0] pats[3];
    logic [3:0]   rlist[7];

    initial begin
        pats[0]  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978,
                    64'hDEADBEEFCAFEF00D, 64'h8000000000000001};
        pats[1]  = {10{32'hA5C3_5A3C}};
        pats[2]  = {64'h80400C0600000000, 64'h000102030405060F, 64'h08090A0B0C0D0E0F,
                    64'h0001020304050607, 64'h08090A0B0C0D0E0F};
        rlist[0] = 4'd12; rlist[1] = 4'd8; rlist[2] = 4'd6; rlist[3] = 4'd0;
        rlist[4] = 4'd15; rlist[5] = 4'd1; rlist[6] = 4'd3;

        rst = 1'b1; start = 1'b0; rounds = 4'd0; state_in = '0;
        repeat (2) @(negedge clk);
        chk("reset busy1", 320'(busy1), 320'd0);
        chk("reset done1", 320'(done1), 320'd0);
        chk("reset state1", so1, 320'd0);
        chk("reset busy2", 320'(busy2), 320'd0);
        chk("reset done2", 320'(done2), 320'd0);
        chk("reset state2", so2, 320'd0);
        rst = 1'b0;

        // First p^a round from the zero state, constant 0xF0
        issue(4'd12, 320'd0);
        @(negedge clk);
        chk("busy after E1", 320'(busy1), 320'd1);
        chk("single round", so1, {64'h001E0F00000000F0, 64'h00000001E0000770,
                                  64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0, 64'h0});
        wait_idle();

        foreach (rlist[ri]) begin
            foreach (pats[pi]) begin
                issue(rlist[ri], pats[pi]);
                wait_idle();
            end
        end

        // Start held high: each op is accepted in the previous done cycle
        @(negedge clk);
        rounds = 4'd6;
        state_in = pats[0];
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            state_in = {state_in[318:0], state_in[319]} ^ 320'(k);
        end
        start = 1'b0;
        wait_idle();

        // Extra start pulse at E3 must be ignored
        issue(4'd12, pats[1]);
        @(negedge clk);
        @(negedge clk);
        rounds = 4'd1;
        state_in = pats[2];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-run
        issue(4'd12, pats[2]);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy1", 320'(busy1), 320'd0);
        chk("midrst done1", 320'(done1), 320'd0);
        chk("midrst state1", so1, 320'd0);
        chk("midrst busy2", 320'(busy2), 320'd0);
        chk("midrst done2", 320'(done2), 320'd0);
        chk("midrst state2", so2, 320'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(4'd8, pats[0]);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
